// File: rtl/hab_event_logger.sv
// rtl/hab_event_logger.sv - output-bus event histogram and schedule checker (checker under HAB_LOGGER_CHECK_EN)
module hab_event_logger #(
    parameter int CW = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [2:0]    display,
    input  logic [5:0]    act,
    input  logic          clr,
    input  logic          rd_req,
    input  logic [2:0]    rd_sel,
    output logic          rd_valid,
    output logic [CW-1:0] rd_data,
    output logic          round_done,
    output logic          err,
    output logic [3:0]    err_slot
);
    localparam logic [3:0] SLOT_PRIME = 4'd13;
    localparam logic [3:0] SLOT_LAST  = 4'd12;

    logic [3:0]    slot;
    // Entry 0 is never written and reads as zero; entry 7 holds the error count.
    logic [CW-1:0] cnt [8];
    logic          sample_en;
    logic          is_event;
    logic          inc_en;
    logic [2:0]    inc_idx;

    assign sample_en = (slot != SLOT_PRIME) && !clr;
    assign is_event  = (display != 3'd0) && (display != 3'd7);

`ifdef HAB_LOGGER_CHECK_EN
    logic [5:0] pattern;
    logic       slot_ok;
    logic       bad;
    logic       err_en;

    always_comb begin
        pattern = 6'b000000;
        case (display)
            3'd1:    pattern = 6'b100000;
            3'd2:    pattern = 6'b010000;
            3'd3:    pattern = 6'b001000;
            3'd4:    pattern = 6'b000100;
            3'd5:    pattern = 6'b000010;
            3'd6:    pattern = 6'b000001;
            default: pattern = 6'b000000;
        endcase
    end

    always_comb begin
        slot_ok = 1'b0;
        case (slot)
            4'd0, 4'd3, 4'd6, 4'd9: slot_ok = (display == 3'd1);
            4'd1, 4'd5, 4'd10:      slot_ok = (display == 3'd2);
            4'd2, 4'd7, 4'd12:      slot_ok = (display == 3'd3);
            4'd4, 4'd11:            slot_ok = (display == 3'd4);
            4'd8:                   slot_ok = (display == 3'd5) || (display == 3'd6);
            default:                slot_ok = 1'b0;
        endcase
    end

    assign bad     = (display == 3'd7) || (act != pattern) || ((display != 3'd0) && !slot_ok);
    assign err_en  = sample_en && bad;
    assign inc_en  = err_en || (sample_en && is_event);
    assign inc_idx = err_en ? 3'd7 : display;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            err      <= 1'b0;
            err_slot <= 4'd0;
        end else if (clr) begin
            err      <= 1'b0;
            err_slot <= 4'd0;
        end else if (err_en) begin
            err <= 1'b1;
            if (!err)
                err_slot <= slot;
        end
    end
`else
    logic unused_act;

    assign unused_act = ^act;
    assign inc_en     = sample_en && is_event;
    assign inc_idx    = display;
    assign err        = 1'b0;
    assign err_slot   = 4'd0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            slot       <= SLOT_PRIME;
            round_done <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            for (int i = 0; i < 8; i++)
                cnt[i] <= '0;
        end else begin
            // Priming and the last slot both lead into slot 0.
            slot       <= ((slot == SLOT_PRIME) || (slot == SLOT_LAST)) ? 4'd0 : slot + 4'd1;
            round_done <= (slot == SLOT_LAST);
            rd_valid   <= rd_req;
            if (rd_req)
                rd_data <= cnt[rd_sel];
            if (clr) begin
                for (int i = 0; i < 8; i++)
                    cnt[i] <= '0;
            end else if (inc_en && (cnt[inc_idx] != {CW{1'b1}})) begin
                cnt[inc_idx] <= cnt[inc_idx] + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_hab_event_logger.sv
// tb/tb_hab_event_logger.sv - randomized bench for hab_event_logger against a slot/histogram reference model
module tb_hab_event_logger;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [2:0]    display = 3'd0;
    logic [5:0]    act = 6'd0;
    logic          clr = 1'b0;
    logic          rd_req = 1'b0;
    logic [2:0]    rd_sel = 3'd0;
    logic          rd_valid;
    logic [CW-1:0] rd_data;
    logic          round_done;
    logic          err;
    logic [3:0]    err_slot;

    hab_event_logger #(.CW(CW)) dut (
        .Clk(Clk), .Rst(Rst), .display(display), .act(act), .clr(clr),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid), .rd_data(rd_data),
        .round_done(round_done), .err(err), .err_slot(err_slot)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: histogram counts plus a sample index since priming.
    int  sched [13] = '{1, 2, 3, 1, 4, 2, 1, 3, 5, 1, 2, 4, 3};
    int  cnt [8];
    bit  m_err;
    int  m_eslot;
    bit  primed;
    int  k;
    bit  e_rv;
    int  e_rd;
    bit  e_rnd;
    logic [10:0] obs, exp_v;

    function automatic int pat_of(int c);
        return (c >= 1 && c <= 6) ? (1 << (6 - c)) : 0;
    endfunction

    task automatic model_sample(int s);
        int c;
        bit legal, bad;
        c = display;
        legal = (c == 0) || (c == sched[s]) || (sched[s] == 5 && c == 6);
        bad = (c == 7) || (int'(act) != pat_of(c)) || !legal;
`ifdef HAB_LOGGER_CHECK_EN
        if (bad) begin
            if (cnt[7] < MAX) cnt[7]++;
            if (!m_err) m_eslot = s;
            m_err = 1'b1;
        end else if (c != 0 && cnt[c] < MAX) begin
            cnt[c]++;
        end
`else
        if (c >= 1 && c <= 6 && cnt[c] < MAX) cnt[c]++;
`endif
    endtask

    task automatic tick();
        @(posedge Clk);
        if (Rst) begin
            foreach (cnt[i]) cnt[i] = 0;
            m_err = 0; m_eslot = 0; primed = 0; k = 0;
            e_rv = 0; e_rd = 0; e_rnd = 0;
        end else begin
            e_rv = rd_req;
            if (rd_req) e_rd = (rd_sel == 0) ? 0 : cnt[rd_sel];
            if (!primed) begin
                primed = 1; k = 0; e_rnd = 0;
            end else begin
                e_rnd = ((k % 13) == 12);
                if (clr) begin
                    foreach (cnt[i]) cnt[i] = 0;
                    m_err = 0; m_eslot = 0;
                end else begin
                    model_sample(k % 13);
                end
                k++;
            end
        end
        exp_v = {e_rv, CW'(e_rd), e_rnd, m_err, 4'(m_eslot)};
        @(negedge Clk);
        obs = {rd_valid, rd_data, round_done, err, err_slot};
    endtask

    task automatic drive_sched();
        int s, c;
        s = k % 13;
        c = sched[s];
        if (c == 5 && $urandom_range(0, 1) == 1) c = 6;
        display = 3'(c);
        act = 6'(pat_of(c));
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if (obs !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outputs obs=%h exp=%h", obs, 11'd0);
        end
        Rst = 1'b0;
    endtask

    task automatic test_round();
        int rounds;
        rounds = 0;
        display = 3'd6; act = 6'b000001;
        tick();
        for (int i = 0; i < 13; i++) begin
            drive_sched();
            if (k % 13 == 8) begin display = 3'd0; act = 6'd0; end
            tick();
            rounds += round_done;
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL round_cycle%0d obs=%h exp=%h", i, obs, exp_v);
            end
        end
        n_cmp++;
        if (rounds != 1) begin
            n_bad++;
            $display("FAIL round_done_count got=%0d want=1", rounds);
        end
        display = 3'd0; act = 6'd0;
        for (int sel = 1; sel <= 7; sel++) begin
            drive_sched();
            rd_req = 1'b1; rd_sel = 3'(sel);
            tick();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL round_read sel=%0d obs=%h exp=%h", sel, obs, exp_v);
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 6) begin
                drive_sched();
            end else begin
                display = 3'($urandom_range(0, 7));
                act = ($urandom_range(0, 1) == 1) ? 6'(pat_of($urandom_range(0, 6))) : 6'($urandom);
            end
            rd_req = 1'($urandom_range(0, 1));
            rd_sel = 3'($urandom_range(0, 7));
            clr = ($urandom_range(0, 39) == 0);
            tick();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL random_cycle%0d obs=%h exp=%h", i, obs, exp_v);
            end
        end
        clr = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_saturation();
        clr = 1'b1; display = 3'd0; act = 6'd0;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 13 * 6; i++) begin
            drive_sched();
            tick();
        end
        rd_req = 1'b1; rd_sel = 3'd1;
        drive_sched();
        tick();
        rd_req = 1'b0;
        n_cmp++;
        if (obs !== exp_v || rd_data !== CW'(MAX)) begin
            n_bad++;
            $display("FAIL saturation rd_data=%0d want=%0d obs=%h exp=%h", rd_data, MAX, obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 30; i++) begin
            drive_sched();
            rd_req = 1'b1; rd_sel = 3'd1;
            tick();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL b2b_read%0d obs=%h exp=%h", i, obs, exp_v);
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_clr_read();
        for (int i = 0; i < 20; i++) begin drive_sched(); tick(); end
        clr = 1'b1; rd_req = 1'b1; rd_sel = 3'd1;
        drive_sched();
        tick();
        clr = 1'b0;
        n_cmp++;
        if (obs !== exp_v || rd_data === CW'(0)) begin
            n_bad++;
            $display("FAIL clr_read_preclear obs=%h exp=%h", obs, exp_v);
        end
        display = 3'd0; act = 6'd0;
        for (int sel = 1; sel <= 7; sel++) begin
            rd_sel = 3'(sel);
            tick();
            n_cmp++;
            if (obs !== exp_v || rd_data !== CW'(0)) begin
                n_bad++;
                $display("FAIL clr_zero sel=%0d obs=%h exp=%h", sel, obs, exp_v);
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_mid_reset();
        int when;
        for (int i = 0; i < 5; i++) begin drive_sched(); tick(); end
        Rst = 1'b1;
        rd_req = 1'b1; rd_sel = 3'd1;
        tick();
        rd_req = 1'b0;
        Rst = 1'b0;
        n_cmp++;
        if (obs !== 11'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs obs=%h exp=%h", obs, 11'd0);
        end
        display = 3'd1; act = 6'b100000;
        tick();
        when = -1;
        for (int i = 0; i < 14; i++) begin
            drive_sched();
            rd_req = (i == 13); rd_sel = 3'd1;
            tick();
            if (round_done && when < 0) when = i;
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL midreset_cycle%0d obs=%h exp=%h", i, obs, exp_v);
            end
        end
        rd_req = 1'b0;
        n_cmp++;
        if (when != 12 || rd_data !== CW'(4)) begin
            n_bad++;
            $display("FAIL midreset_prime round_at=%0d want=12 cnt1=%0d want=4", when, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_round();
        test_random();
        test_saturation();
        test_back_to_back();
        test_clr_read();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hab_event_logger.md
# hab_event_logger

Monitor and event logger on the consumer side of the home-automation controller's output bus. It samples the controller's registered 3-bit `display` code and 6-bit actuator vector every cycle. It keeps a per-event histogram in saturating counters and checks each sample against the controller's fixed 13-slot sensor schedule. It sits beside the controller, and its counters are read through a single-request read port.

## Interface

Parameters:
- `CW`, default 8: width of each event counter and of the error counter.

Ports:
- `Clk`, in, 1: clock.
- `Rst`, in, 1: reset, synchronous, active-high.
- `display`, in, 3: controller event code (0 = none, 1..6 = event).
- `act`, in, 6: actuator vector, packed as {fdoor, rdoor, alarmbuzz, winbuzz, heater, cooler}.
- `clr`, in, 1: synchronous clear of counters and error state.
- `rd_req`, in, 1: read request, one-cycle pulse.
- `rd_sel`, in, 3: counter select. 1..6 select event counters; 7 selects the error counter; 0 returns 0.
- `rd_valid`, out, 1: read data valid, one-cycle pulse.
- `rd_data`, out, CW: read data.
- `round_done`, out, 1: pulses on the sample for schedule slot 12.
- `err`, out, 1: sticky error flag.
- `err_slot`, out, 4: slot index of the first error since the last clear or reset.

## Operation

- Codes and their required `act` pattern:
  - 1 front door: `act` = 6'b100000.
  - 2 rear door: 6'b010000.
  - 3 fire alarm: 6'b001000.
  - 4 window: 6'b000100.
  - 5 heater: 6'b000010.
  - 6 cooler: 6'b000001.
  - 0: `act` = 0.
- Schedule, slots 0..12, and the sensor each slot polls:
  - FD: slots 0, 3, 6, 9.
  - RD: slots 1, 5, 10.
  - FA: slots 2, 7, 12.
  - W: slots 4, 11.
  - T: slot 8, which allows code 5 or 6.
- Slot pointer `slot`, 4 bits, reset value 13 (priming state).
  - The sample at the first edge after `Rst` falls reflects the controller's reset value. It is discarded, and `slot` moves 13 -> 0.
  - After that, each edge attributes the current sample to `slot`, then advances `slot`: 0..11 -> +1, 12 -> 0.
- Valid sample: the code is nonzero, in 1..6, and `act` matches that code's pattern.
  - A valid sample increments counter[code].
  - Counters saturate at 2^CW-1; they never wrap.
- Error sample (checker compiled in only), any of:
  - code 7;
  - `act` does not match the code's pattern, including code 0 with `act` nonzero;
  - a nonzero code that is illegal for the current slot.
- On an error sample:
  - the error counter increments, saturating;
  - `err` is set;
  - `err_slot` is loaded only if `err` was 0;
  - no event counter is incremented.
- `clr`:
  - clears all counters, `err`, and `err_slot`; `slot` is untouched;
  - a sample in the same cycle is neither counted nor error-checked.
- Reads:
  - `rd_req` at edge N gives `rd_valid`=1 and `rd_data` for the selected counter after edge N+1.
  - The returned value is the pre-update value at edge N; a same-cycle increment is not visible.
  - `rd_req` together with `clr` returns the pre-clear value.
  - Back-to-back requests are allowed, one per cycle.

## Timing

- Reset values:
  - `rd_valid`=0, `rd_data`=0, `round_done`=0, `err`=0, `err_slot`=0.
  - All counters 0; `slot`=13.
- Read latency is 1 cycle. `rd_data` holds its value while `rd_valid`=0.
- `round_done` is registered: high for one cycle after the edge that samples slot 12, which is every 13 cycles in steady state.
- `Rst` mid-operation: all state returns to reset values at that edge, and priming restarts. A read in flight is dropped (`rd_valid`=0).
- `err` and `err_slot` update at the same edge that samples the error.

## Configuration

- `HAB_LOGGER_CHECK_EN` defined:
  - The schedule/consistency checker, error counter, `err`, and `err_slot` are present.
- `HAB_LOGGER_CHECK_EN` not defined:
  - There is no slot legality or `act` check.
  - Any code 1..6 increments counter[code]; codes 0 and 7 are ignored.
  - `err`=0, `err_slot`=0, and `rd_sel`=7 reads 0.
  - `slot` and `round_done` remain.

## Test plan

- Drive the controller with SFD=SRD=SFA=SW=1 and ST=60 for one full round after priming. Required: `round_done` once; counters read back 4, 3, 3, 2, 0, 0 for codes 1..6; `err`=0.
- ST=40 and all other sensors 0 for 26 sampled cycles. Required: counter5=2, all others 0, `err`=0.
- Force `display`=2 with `act`=6'b010000 in slot 0. Required: `err`=1, `err_slot`=0, error counter 1, counter2 unchanged. A later error in slot 4 leaves `err_slot`=0.
- CW=4, SFD held high for 65 rounds. Required: counter1 saturates at 15 and stays there.
- `rd_req` with `rd_sel`=1 in the same cycle as a valid FD sample, with counter1 at 3. Required: `rd_data`=3 one cycle later; a following read returns 4.
- Assert `clr` and `rd_req` together, then `Rst` mid-round. Required: the read returns the pre-clear value; after clear, all counters read 0; after `Rst`, `slot` primes again and the first post-reset sample is ignored.
